// File: rtl/sim_dev_arbiter.sv
// sim_dev_arbiter: two-requester round-robin arbiter and sequencer in front
// of the single-outstanding simulation device port. in0 carries instruction
// fetches and in1 carries data accesses. One transaction is in flight at a
// time. A watchdog bounds the wait for the device response and substitutes a
// synthetic 0xDEADBEEF response when it fires.
//
// Handshake rule for every valid/ready pair on this block: a transfer happens
// on a rising clock edge where both valid and ready are 1. A source holds valid
// and its payload stable until that edge. Valid never waits on ready. The
// response path is the only exception where ready depends combinationally on
// the owner's resp_ready (out_resp_ready = owner resp_ready in WAIT_RESP).
module sim_dev_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        in0_req_valid,
  output logic        in0_req_ready,
  input  logic        in0_req_bits_is_cached,
  input  logic        in0_req_bits_is_aligned,
  input  logic [31:0] in0_req_bits_addr,
  input  logic [31:0] in0_req_bits_data,
  input  logic        in0_req_bits_func,
  input  logic [3:0]  in0_req_bits_wstrb,
  output logic        in0_resp_valid,
  input  logic        in0_resp_ready,
  output logic [31:0] in0_resp_bits_data,

  input  logic        in1_req_valid,
  output logic        in1_req_ready,
  input  logic        in1_req_bits_is_cached,
  input  logic        in1_req_bits_is_aligned,
  input  logic [31:0] in1_req_bits_addr,
  input  logic [31:0] in1_req_bits_data,
  input  logic        in1_req_bits_func,
  input  logic [3:0]  in1_req_bits_wstrb,
  output logic        in1_resp_valid,
  input  logic        in1_resp_ready,
  output logic [31:0] in1_resp_bits_data,

  output logic        out_req_valid,
  input  logic        out_req_ready,
  output logic        out_req_bits_is_cached,
  output logic        out_req_bits_is_aligned,
  output logic [31:0] out_req_bits_addr,
  output logic [31:0] out_req_bits_data,
  output logic        out_req_bits_func,
  output logic [3:0]  out_req_bits_wstrb,

  input  logic        out_resp_valid,
  output logic        out_resp_ready,
  input  logic [31:0] out_resp_bits_data,

  output logic        timeout_err,
  output logic [1:0]  dbg_state
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0] SYNTH_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             owner;
  logic             rr_next;
  logic             to_pending;
  logic [CNT_W-1:0] wd_cnt;

  logic             grant;
  logic             grant_vld;
  logic             req_fire;
  logic             own_resp_ready;
  logic             resp_valid_mux;
  logic [31:0]      resp_data_mux;
  logic             dev_fire;
  logic             synth_fire;
  logic             resp_done;
  logic             wd_fire;

  assign dbg_state = state;

  // Grant selection, response muxing and the fire/watchdog strobes.
  always_comb begin
    grant_vld      = in0_req_valid | in1_req_valid;
    grant          = 1'b0;
    if (in0_req_valid && in1_req_valid) begin
      grant = rr_next;
    end else if (in1_req_valid) begin
      grant = 1'b1;
    end
    req_fire       = (state == IDLE) && grant_vld;
    own_resp_ready = owner ? in1_resp_ready : in0_resp_ready;
    resp_valid_mux = to_pending ? 1'b1 : out_resp_valid;
    resp_data_mux  = to_pending ? SYNTH_DATA : out_resp_bits_data;
    dev_fire       = (state == WAIT_RESP) && !to_pending && out_resp_valid && own_resp_ready;
    synth_fire     = (state == WAIT_RESP) && to_pending && own_resp_ready;
    resp_done      = dev_fire | synth_fire;
    // Watchdog fires on the last allowed WAIT_RESP cycle without a response.
    wd_fire        = (state == WAIT_RESP) && !to_pending && !dev_fire && (wd_cnt == CNT_LAST);
  end

  // Next-state and handshake outputs; everything defaults to idle values.
  always_comb begin
    state_nxt          = state;
    in0_req_ready      = 1'b0;
    in1_req_ready      = 1'b0;
    out_req_valid      = 1'b0;
    out_resp_ready     = 1'b0;
    in0_resp_valid     = 1'b0;
    in1_resp_valid     = 1'b0;
    in0_resp_bits_data = '0;
    in1_resp_bits_data = '0;
    case (state)
      IDLE: begin
        in0_req_ready = grant_vld && !grant;
        in1_req_ready = grant_vld && grant;
        if (grant_vld) state_nxt = SEND;
      end
      SEND: begin
        out_req_valid = 1'b1;
        if (out_req_ready) state_nxt = WAIT_RESP;
      end
      WAIT_RESP: begin
        // Device is stalled while the synthetic response is pending.
        out_resp_ready = !to_pending && own_resp_ready;
        if (owner) begin
          in1_resp_valid     = resp_valid_mux;
          in1_resp_bits_data = resp_data_mux;
        end else begin
          in0_resp_valid     = resp_valid_mux;
          in0_resp_bits_data = resp_data_mux;
        end
        if (resp_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the winner's request fields and its identity on the input fire.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner                   <= 1'b0;
      out_req_bits_is_cached  <= 1'b0;
      out_req_bits_is_aligned <= 1'b0;
      out_req_bits_addr       <= '0;
      out_req_bits_data       <= '0;
      out_req_bits_func       <= 1'b0;
      out_req_bits_wstrb      <= '0;
    end else if (req_fire) begin
      owner                   <= grant;
      out_req_bits_is_cached  <= grant ? in1_req_bits_is_cached  : in0_req_bits_is_cached;
      out_req_bits_is_aligned <= grant ? in1_req_bits_is_aligned : in0_req_bits_is_aligned;
      out_req_bits_addr       <= grant ? in1_req_bits_addr       : in0_req_bits_addr;
      out_req_bits_data       <= grant ? in1_req_bits_data       : in0_req_bits_data;
      out_req_bits_func       <= grant ? in1_req_bits_func       : in0_req_bits_func;
      out_req_bits_wstrb      <= grant ? in1_req_bits_wstrb      : in0_req_bits_wstrb;
    end
  end

  // Round-robin pointer: after any completed response the other side is favoured.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_next <= 1'b0;
    end else if (resp_done) begin
      rr_next <= ~owner;
    end
  end

  // Watchdog counter (saturating) and synthetic-response pending flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt     <= '0;
      to_pending <= 1'b0;
    end else if (state == SEND && out_req_ready) begin
      wd_cnt     <= '0;
      to_pending <= 1'b0;
    end else if (state == WAIT_RESP) begin
      if (resp_done) begin
        to_pending <= 1'b0;
      end else begin
        if (wd_cnt != CNT_LAST) wd_cnt <= wd_cnt + 1'b1;
        if (wd_fire) to_pending <= 1'b1;
      end
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timeout_err <= 1'b0;
    end else if (wd_fire) begin
      timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sim_dev_arbiter.sv
// Directed bench for sim_dev_arbiter with TIMEOUT = 8. Request records and
// response records are pushed to expected queues when stimulus is driven and
// popped by negedge monitors when the DUT transfers them.
module tb_sim_dev_arbiter;

  localparam int W = 80;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        in0_req_valid, in0_req_ready, in0_req_bits_is_cached, in0_req_bits_is_aligned;
  logic [31:0] in0_req_bits_addr, in0_req_bits_data;
  logic        in0_req_bits_func;
  logic [3:0]  in0_req_bits_wstrb;
  logic        in0_resp_valid, in0_resp_ready;
  logic [31:0] in0_resp_bits_data;
  logic        in1_req_valid, in1_req_ready, in1_req_bits_is_cached, in1_req_bits_is_aligned;
  logic [31:0] in1_req_bits_addr, in1_req_bits_data;
  logic        in1_req_bits_func;
  logic [3:0]  in1_req_bits_wstrb;
  logic        in1_resp_valid, in1_resp_ready;
  logic [31:0] in1_resp_bits_data;
  logic        out_req_valid, out_req_ready, out_req_bits_is_cached, out_req_bits_is_aligned;
  logic [31:0] out_req_bits_addr, out_req_bits_data;
  logic        out_req_bits_func;
  logic [3:0]  out_req_bits_wstrb;
  logic        out_resp_valid, out_resp_ready;
  logic [31:0] out_resp_bits_data;
  logic        timeout_err;
  logic [1:0]  dbg_state;

  sim_dev_arbiter #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .in0_req_valid(in0_req_valid), .in0_req_ready(in0_req_ready),
    .in0_req_bits_is_cached(in0_req_bits_is_cached), .in0_req_bits_is_aligned(in0_req_bits_is_aligned),
    .in0_req_bits_addr(in0_req_bits_addr), .in0_req_bits_data(in0_req_bits_data),
    .in0_req_bits_func(in0_req_bits_func), .in0_req_bits_wstrb(in0_req_bits_wstrb),
    .in0_resp_valid(in0_resp_valid), .in0_resp_ready(in0_resp_ready),
    .in0_resp_bits_data(in0_resp_bits_data),
    .in1_req_valid(in1_req_valid), .in1_req_ready(in1_req_ready),
    .in1_req_bits_is_cached(in1_req_bits_is_cached), .in1_req_bits_is_aligned(in1_req_bits_is_aligned),
    .in1_req_bits_addr(in1_req_bits_addr), .in1_req_bits_data(in1_req_bits_data),
    .in1_req_bits_func(in1_req_bits_func), .in1_req_bits_wstrb(in1_req_bits_wstrb),
    .in1_resp_valid(in1_resp_valid), .in1_resp_ready(in1_resp_ready),
    .in1_resp_bits_data(in1_resp_bits_data),
    .out_req_valid(out_req_valid), .out_req_ready(out_req_ready),
    .out_req_bits_is_cached(out_req_bits_is_cached), .out_req_bits_is_aligned(out_req_bits_is_aligned),
    .out_req_bits_addr(out_req_bits_addr), .out_req_bits_data(out_req_bits_data),
    .out_req_bits_func(out_req_bits_func), .out_req_bits_wstrb(out_req_bits_wstrb),
    .out_resp_valid(out_resp_valid), .out_resp_ready(out_resp_ready),
    .out_resp_bits_data(out_resp_bits_data),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_req_q[$];
  logic [W-1:0] exp_resp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rec(input logic c, input logic a, input logic [31:0] ad,
                                       input logic [31:0] d, input logic f, input logic [3:0] s);
    return W'({c, a, f, s, ad, d});
  endfunction

  function automatic logic [W-1:0] out_rec();
    return rec(out_req_bits_is_cached, out_req_bits_is_aligned, out_req_bits_addr,
               out_req_bits_data, out_req_bits_func, out_req_bits_wstrb);
  endfunction

  // ---------------- monitors ----------------
  // Request fires, request stability while stalled, response fires, one-hot responses.
  always @(negedge clock) begin
    if (reset) begin
      if (out_req_valid && out_req_ready) begin
        chk("req_expected", W'(exp_req_q.size() != 0), W'(1));
        if (exp_req_q.size() != 0) chk("out_req", out_rec(), exp_req_q.pop_front());
      end else if (out_req_valid && exp_req_q.size() != 0) begin
        chk("req_hold", out_rec(), exp_req_q[0]);
      end
      if (in0_resp_valid && in0_resp_ready) begin
        chk("resp0_expected", W'(exp_resp_q.size() != 0), W'(1));
        if (exp_resp_q.size() != 0) chk("resp0", W'({1'b0, in0_resp_bits_data}), exp_resp_q.pop_front());
      end
      if (in1_resp_valid && in1_resp_ready) begin
        chk("resp1_expected", W'(exp_resp_q.size() != 0), W'(1));
        if (exp_resp_q.size() != 0) chk("resp1", W'({1'b1, in1_resp_bits_data}), exp_resp_q.pop_front());
      end
      chk("resp_onehot", W'(in0_resp_valid & in1_resp_valid), W'(0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [W-1:0] r);
    if (p == 0) begin
      in0_req_valid = v; in0_req_bits_is_cached = r[70]; in0_req_bits_is_aligned = r[69];
      in0_req_bits_func = r[68]; in0_req_bits_wstrb = r[67:64];
      in0_req_bits_addr = r[63:32]; in0_req_bits_data = r[31:0];
    end else begin
      in1_req_valid = v; in1_req_bits_is_cached = r[70]; in1_req_bits_is_aligned = r[69];
      in1_req_bits_func = r[68]; in1_req_bits_wstrb = r[67:64];
      in1_req_bits_addr = r[63:32]; in1_req_bits_data = r[31:0];
    end
  endtask

  // Present one request, wait for its grant, then withdraw it.
  task automatic req_once(input int p, input logic [W-1:0] r);
    int n = 0;
    set_req(p, 1'b1, r);
    exp_req_q.push_back(r);
    @(negedge clock);
    while (!(p == 0 ? in0_req_ready : in1_req_ready) && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("req_granted", W'(p == 0 ? in0_req_ready : in1_req_ready), W'(1));
    tick();
    set_req(p, 1'b0, r);
  endtask

  // Device model: accept after req_wait stall cycles, answer resp_delay cycles later.
  task automatic dev_serve(input int own, input int req_wait, input int resp_delay, input logic [31:0] d);
    int n = 0;
    logic done = 1'b0;
    exp_resp_q.push_back(W'({own[0], d}));
    while (!out_req_valid && n < 50) begin
      tick();
      n++;
    end
    chk("dev_req_seen", W'(out_req_valid), W'(1));
    repeat (req_wait) tick();
    out_req_ready = 1'b1;
    tick();
    out_req_ready = 1'b0;
    repeat (resp_delay) tick();
    out_resp_valid = 1'b1;
    out_resp_bits_data = d;
    n = 0;
    do begin
      @(negedge clock);
      done = out_resp_ready;
      tick();
      n++;
    end while (!done && n < 50);
    chk("dev_resp_taken", W'(done), W'(1));
    out_resp_valid = 1'b0;
  endtask

  // Requester-side backpressure: hold in0_resp_ready low for 3 response cycles.
  task automatic bp_requester();
    int n = 0;
    @(negedge clock);
    while (!out_resp_valid && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("bp_resp_seen", W'(out_resp_valid), W'(1));
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clock);
      chk("bp_out_resp_ready_low", W'(out_resp_ready), W'(0));
      chk("bp_in0_resp_valid", W'(in0_resp_valid), W'(1));
    end
    tick();
    in0_resp_ready = 1'b1;
    @(negedge clock);
    chk("bp_out_resp_ready_high", W'(out_resp_ready), W'(1));
  endtask

  // in1 pulses valid for one cycle while in0 owns the device.
  task automatic late_in1();
    int n = 0;
    @(negedge clock);
    while (dbg_state != 2'd2 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("late_wait_state", W'(dbg_state), W'(2));
    tick();
    set_req(1, 1'b1, rec(1'b0, 1'b1, 32'h4000_0020, 32'hABCD_0000, 1'b1, 4'h1));
    @(negedge clock);
    chk("late_in1_ready", W'(in1_req_ready), W'(0));
    tick();
    set_req(1, 1'b0, '0);
  endtask

  // Watchdog against a hung bench.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] r, ra, rb;
    set_req(0, 1'b0, '0);
    set_req(1, 1'b0, '0);
    in0_resp_ready = 1'b1;
    in1_resp_ready = 1'b1;
    out_req_ready = 1'b0;
    out_resp_valid = 1'b0;
    out_resp_bits_data = '0;
    reset = 1'b0;

    // Reset values.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in0_req_ready", W'(in0_req_ready), W'(0));
    chk("rst_in1_req_ready", W'(in1_req_ready), W'(0));
    chk("rst_in0_resp_valid", W'(in0_resp_valid), W'(0));
    chk("rst_in1_resp_valid", W'(in1_resp_valid), W'(0));
    chk("rst_out_req_valid", W'(out_req_valid), W'(0));
    chk("rst_out_req_bits", out_rec(), W'(0));
    chk("rst_out_resp_ready", W'(out_resp_ready), W'(0));
    chk("rst_timeout_err", W'(timeout_err), W'(0));
    chk("rst_state", W'(dbg_state), W'(0));
    tick();
    reset = 1'b1;

    // Single read on in0.
    r = rec(1'b1, 1'b1, 32'h1000_0000, 32'h0, 1'b0, 4'h0);
    set_req(0, 1'b1, r);
    exp_req_q.push_back(r);
    @(negedge clock);
    chk("t1_in0_ready", W'(in0_req_ready), W'(1));
    chk("t1_in1_ready", W'(in1_req_ready), W'(0));
    tick();
    set_req(0, 1'b0, r);
    fork
      dev_serve(0, 0, 1, 32'h1234_5678);
      begin
        @(negedge clock);
        chk("t1_out_valid_c1", W'(out_req_valid), W'(1));
        chk("t1_out_addr_c1", W'(out_req_bits_addr), W'(32'h1000_0000));
      end
    join
    chk("t1_idle", W'(dbg_state), W'(0));

    // Contention from reset: grants in0, in1, in0, in1.
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    ra = rec(1'b1, 1'b1, 32'h0000_1000, 32'h0, 1'b0, 4'h0);
    rb = rec(1'b0, 1'b1, 32'h8000_0010, 32'hCAFE_F00D, 1'b1, 4'hF);
    set_req(0, 1'b1, ra); exp_req_q.push_back(ra);
    set_req(1, 1'b1, rb); exp_req_q.push_back(rb);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dev_serve(k % 2, 0, 1, 32'hD000_0000 + 32'(k));
      if (k == 0) begin
        ra = rec(1'b1, 1'b1, 32'h0000_1004, 32'h0, 1'b0, 4'h0);
        set_req(0, 1'b1, ra); exp_req_q.push_back(ra);
      end else if (k == 1) begin
        rb = rec(1'b0, 1'b0, 32'h8000_0020, 32'h0, 1'b0, 4'h0);
        set_req(1, 1'b1, rb); exp_req_q.push_back(rb);
      end else if (k == 2) begin
        set_req(0, 1'b1, rec(1'b1, 1'b1, 32'h0000_1008, 32'h0, 1'b0, 4'h0));
      end else begin
        set_req(0, 1'b0, '0);
        set_req(1, 1'b0, '0);
      end
    end
    repeat (2) tick();
    chk("t2_idle", W'(dbg_state), W'(0));

    // Backpressure on both the device request and the requester response.
    r = rec(1'b0, 1'b1, 32'h2000_0040, 32'h5555_AAAA, 1'b1, 4'h3);
    in0_resp_ready = 1'b0;
    fork
      req_once(0, r);
      dev_serve(0, 5, 1, 32'h0BAD_F00D);
      bp_requester();
    join
    in0_resp_ready = 1'b1;
    repeat (2) tick();

    // Timeout: device accepts the request but never answers.
    r = rec(1'b1, 1'b0, 32'h3000_0000, 32'h0, 1'b0, 4'h0);
    fork
      req_once(0, r);
      begin
        for (int n = 0; n < 50 && !out_req_valid; n++) tick();
        out_req_ready = 1'b1;
        tick();
        out_req_ready = 1'b0;
      end
    join
    exp_resp_q.push_back(W'({1'b0, 32'hDEAD_BEEF}));
    in0_resp_ready = 1'b0;
    repeat (7) tick();
    @(negedge clock);
    chk("to_w7_state", W'(dbg_state), W'(2));
    chk("to_w7_resp_valid", W'(in0_resp_valid), W'(0));
    chk("to_w7_err", W'(timeout_err), W'(0));
    tick();
    out_resp_valid = 1'b1;
    out_resp_bits_data = 32'h1111_1111;
    @(negedge clock);
    chk("to_w8_resp_valid", W'(in0_resp_valid), W'(1));
    chk("to_w8_resp_data", W'(in0_resp_bits_data), W'(32'hDEAD_BEEF));
    chk("to_w8_out_resp_ready", W'(out_resp_ready), W'(0));
    chk("to_w8_err", W'(timeout_err), W'(1));
    tick();
    out_resp_valid = 1'b0;
    in0_resp_ready = 1'b1;
    @(negedge clock);
    chk("to_w9_resp_held", W'(in0_resp_valid), W'(1));
    tick();
    @(negedge clock);
    chk("to_back_idle", W'(dbg_state), W'(0));
    tick();
    fork
      req_once(0, rec(1'b0, 1'b0, 32'h3000_0100, 32'h0, 1'b0, 4'h0));
      dev_serve(0, 0, 2, 32'h600D_0001);
    join
    chk("to_err_sticky", W'(timeout_err), W'(1));

    // Late requester drop: in1 valid for one cycle while in0 waits for a response.
    fork
      req_once(0, rec(1'b0, 1'b0, 32'h4000_0010, 32'h0, 1'b0, 4'h0));
      dev_serve(0, 0, 3, 32'h7777_0000);
      late_in1();
    join
    repeat (5) tick();
    @(negedge clock);
    chk("late_idle", W'(dbg_state), W'(0));
    chk("late_no_send", W'(out_req_valid), W'(0));
    tick();

    // Reset during SEND aborts the transaction; in0 wins the first grant after.
    r = rec(1'b1, 1'b1, 32'h5000_0000, 32'h0000_0001, 1'b1, 4'hF);
    set_req(0, 1'b1, r);
    tick();
    set_req(0, 1'b0, r);
    @(negedge clock);
    chk("rm_in_send", W'(out_req_valid), W'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("rm_out_req_valid", W'(out_req_valid), W'(0));
    chk("rm_out_req_bits", out_rec(), W'(0));
    chk("rm_state", W'(dbg_state), W'(0));
    chk("rm_timeout_err", W'(timeout_err), W'(0));
    chk("rm_out_resp_ready", W'(out_resp_ready), W'(0));
    tick();
    reset = 1'b1;
    ra = rec(1'b0, 1'b1, 32'h6000_0000, 32'h0, 1'b0, 4'h0);
    rb = rec(1'b1, 1'b1, 32'h6000_0100, 32'h0102_0304, 1'b1, 4'hC);
    set_req(0, 1'b1, ra); exp_req_q.push_back(ra);
    set_req(1, 1'b1, rb); exp_req_q.push_back(rb);
    @(negedge clock);
    chk("rm_first_grant_in0", W'(in0_req_ready), W'(1));
    chk("rm_first_grant_in1", W'(in1_req_ready), W'(0));
    tick();
    dev_serve(0, 0, 1, 32'h6000_AAAA);
    set_req(0, 1'b0, '0);
    dev_serve(1, 0, 1, 32'h6000_BBBB);
    set_req(1, 1'b0, '0);
    repeat (3) tick();

    // Final report.
    chk("req_q_drained", W'(exp_req_q.size()), W'(0));
    chk("resp_q_drained", W'(exp_resp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sim_dev_arbiter.md
# sim_dev_arbiter

Two-requester arbiter and sequencer in front of the single-outstanding simulation device port. Port in0 carries instruction fetches and in1 carries data accesses. The block grants one requester at a time with round-robin fairness and latches the granted request into registers. It then drives that request to the device, routes the single response back to its owner, and guards the response wait with a timeout watchdog.

## Interface
Parameters:
- TIMEOUT, 1024: maximum number of cycles spent in WAIT_RESP before the watchdog fires. Legal range is 2..65535.

Ports (`in{0,1}_*` denotes one port per requester, identical in shape):
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in{0,1}_req_valid  input  1  requester has a request.
- in{0,1}_req_ready  output  1  arbiter accepts the request this cycle.
- in{0,1}_req_bits_is_cached  input  1  cacheability attribute, passed through.
- in{0,1}_req_bits_is_aligned  input  1  alignment attribute, passed through.
- in{0,1}_req_bits_addr  input  32  byte address.
- in{0,1}_req_bits_data  input  32  write data.
- in{0,1}_req_bits_func  input  1  0 = read, 1 = write.
- in{0,1}_req_bits_wstrb  input  4  byte enables.
- in{0,1}_resp_valid  output  1  response for this requester.
- in{0,1}_resp_ready  input  1  requester accepts the response.
- in{0,1}_resp_bits_data  output  32  response data.
- out_req_valid / out_req_ready  output / input  1  request handshake toward the device.
- out_req_bits_{is_cached,is_aligned,addr,data,func,wstrb}  output  1,1,32,32,1,4  latched request fields.
- out_resp_valid / out_resp_ready  input / output  1  response handshake from the device.
- out_resp_bits_data  input  32  device response data.
- timeout_err  output  1  sticky flag, set when the watchdog fires.

## Operation
- The FSM has three states: IDLE, SEND and WAIT_RESP. Reset enters IDLE.
- IDLE:
  - Grant is computed combinationally. If only one requester is valid, that requester wins. If both are valid, the requester indicated by `rr_next` wins.
  - `inX_req_ready` = (state == IDLE) && (grant == X). The other requester sees ready = 0.
  - On the fire, the winner's fields are latched into the `out_req_bits_*` registers and the owner is recorded. The FSM moves to SEND.
- SEND:
  - `out_req_valid` = 1 and the fields are held stable.
  - When `out_req_ready` is 1, the FSM moves to WAIT_RESP and the watchdog counter is cleared to 0.
- WAIT_RESP:
  - `inOwner_resp_valid` = `out_resp_valid`.
  - `inOwner_resp_bits_data` = `out_resp_bits_data`.
  - `out_resp_ready` = `inOwner_resp_ready`.
  - The non-owner sees resp_valid = 0.
  - When the response fires, the FSM returns to IDLE and `rr_next` is set to the non-owner.
  - The counter increments every cycle the response has not fired.
  - When the counter reaches TIMEOUT-1 and the response has not fired, the block returns a synthetic response: the owner sees resp_valid = 1 with data 0xDEADBEEF, held until its resp_ready is 1. `timeout_err` is set. `out_resp_ready` is held at 0 while the synthetic response is pending. When the synthetic response fires, the FSM returns to IDLE.
- A late device response arriving after a timeout is the device's fault. No drop logic is built for it.
- The counter width is clog2(TIMEOUT). It saturates and never wraps.
- `timeout_err` clears only on reset.
- `rr_next` resets to 0, so in0 wins the first contested grant.

## Timing
- Reset values:
  - Every req_ready and resp_valid is 0.
  - `out_req_valid` is 0.
  - `out_req_bits_*` are all 0.
  - `out_resp_ready` is 0.
  - `timeout_err` is 0.
  - `rr_next` is 0.
  - State is IDLE.
- Asserting reset in any state aborts the transaction immediately. The owner is not given a response.
- Latency:
  - Input fire at cycle 0 → `out_req_valid` is high at cycle 1.
  - A device that is always ready fires the request at cycle 1 and is in WAIT_RESP from cycle 2.
  - A response returned at cycle N appears combinationally on the owner's resp port at cycle N, giving zero added response latency.
- Throughput: at most one transaction is in flight, with a minimum of 3 cycles per transaction (IDLE, SEND, WAIT_RESP).
- The response fire and a new request from the other requester in the same cycle do not overlap. The new grant happens in the following IDLE cycle.
- A requester that deasserts valid before being granted loses nothing. Nothing is latched until the fire.
- All outputs toward the device are registered or derived from the state. The only combinational paths are out_resp→in_resp and in_resp_ready→out_resp_ready.

## Test plan
- Single read on in0: addr 0x1000_0000, func 0, with a device that is ready and responds after 1 cycle with data 0x1234_5678. Required: in0_req_ready is 1 in IDLE, out_req_valid at cycle 1 with addr 0x1000_0000, and in0 receives 0x1234_5678. in1 never sees resp_valid.
- Contention: both requesters valid continuously from reset. Required: grants alternate in0, in1, in0, in1 over 4 transactions. The write on in1 (wstrb 0xF, data 0xCAFE_F00D) appears verbatim on out_req_bits.
- Backpressure: out_req_ready held at 0 for 5 cycles, and in0_resp_ready held at 0 for 3 cycles after out_resp_valid rises. Required: out_req_bits stay stable, out_resp_ready mirrors in0_resp_ready, and there is no duplicate fire.
- Timeout with TIMEOUT = 8: the device never responds. Required: after 8 WAIT_RESP cycles the owner gets data 0xDEADBEEF and timeout_err = 1. The next request is accepted normally and timeout_err stays 1.
- Reset mid-transaction: reset is asserted during SEND. Required: out_req_valid drops immediately without waiting for a clock edge, all outputs take their reset values, and the first grant after release goes to in0.
- Late requester drop: in1 is valid for 1 cycle while in0 is in WAIT_RESP, then deasserts. Required: in1 is never granted and nothing is sent on out_req.
